// File: rtl/cfsr_pkg.sv
// rtl/cfsr_pkg.sv - shared definitions for the 4-bit CFSR generator and its monitor
// Contents: FSM state type and encodings, seed and period constants, successor function.
package cfsr_pkg;

    typedef logic [0:0] cfsr_state_t;

    localparam cfsr_state_t ST_ACQUIRE = 1'b0;
    localparam cfsr_state_t ST_LOCKED  = 1'b1;

    localparam logic [3:0] SEED   = 4'b1111;
    localparam int         PERIOD = 16;

    // Feedback term includes the all-zero detect on s[3:1], which splices
    // 0000 into the cycle so all 16 codes appear in one period.
    function automatic logic [3:0] cfsr_next(input logic [3:0] s);
        logic fb;
        fb = (~s[3] & ~s[2] & ~s[1]) ^ s[0];
        return {fb, s[3] ^ fb, s[2], s[1]};
    endfunction

endpackage

// File: rtl/cfsr_monitor.sv
// rtl/cfsr_monitor.sv - lock/error monitor for a 4-bit CFSR sample stream
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid, cfsr_in incoming sample and its qualifier
//   clr               synchronous clear of err_cnt
//   locked            high while in LOCKED
//   err               one-cycle pulse per misprediction while locked
//   wrap              one-cycle pulse on a correctly predicted SEED while locked
//   err_cnt           saturating count of err pulses
module cfsr_monitor
    import cfsr_pkg::*;
#(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       cfsr_in,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);
    localparam logic [3:0] LOSS_N_C = 4'(LOSS_N);

    cfsr_state_t      state_q, state_d;
    logic [3:0]       pred_q, pred_d;
    logic             pred_vld_q, pred_vld_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             hit;
    logic [3:0]       match_inc;
    logic [3:0]       miss_inc;

    assign hit       = (cfsr_in == pred_q);
    assign match_inc = match_cnt_q + 4'd1;
    assign miss_inc  = miss_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        pred_vld_d  = pred_vld_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (in_valid) begin
            if (state_q == ST_ACQUIRE) begin
                // While acquiring, always resync to the incoming sample.
                pred_d     = cfsr_next(cfsr_in);
                pred_vld_d = 1'b1;
                if (!pred_vld_q || !hit) begin
                    match_cnt_d = 4'd0;
                end else if (match_inc == LOCK_N_C) begin
                    state_d     = ST_LOCKED;
                    match_cnt_d = 4'd0;
                    miss_cnt_d  = 4'd0;
                end else begin
                    match_cnt_d = match_inc;
                end
            end else begin
                // Free-running prediction: a single bad sample must not
                // derail the following ones.
                pred_d = cfsr_next(pred_q);
                if (hit) begin
                    miss_cnt_d = 4'd0;
                    wrap_d     = (cfsr_in == SEED);
                end else begin
                    err_d = 1'b1;
                    if (miss_inc == LOSS_N_C) begin
                        state_d     = ST_ACQUIRE;
                        pred_vld_d  = 1'b0;
                        match_cnt_d = 4'd0;
                        miss_cnt_d  = 4'd0;
                    end else begin
                        miss_cnt_d = miss_inc;
                    end
                end
            end
        end

        // clr wins over a same-cycle increment.
        if (clr) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACQUIRE;
            pred_q      <= SEED;
            pred_vld_q  <= 1'b0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            pred_vld_q  <= pred_vld_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked  = (state_q == ST_LOCKED);
    assign err     = err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cfsr_monitor.sv
// tb/tb_cfsr_monitor.sv - self-checking bench for cfsr_monitor
module tb_cfsr_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] cfsr_in;
    logic       clr;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    cfsr_monitor #(.LOCK_N(4), .LOSS_N(2), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .cfsr_in (cfsr_in),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .wrap    (wrap),
        .err_cnt (err_cnt)
    );

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       c;
        logic       e_locked;
        logic       e_err;
        logic       e_wrap;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] seq_tbl [16] = '{4'b1111, 4'b1011, 4'b1001, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0000,
                                 4'b1100, 4'b0110, 4'b0011, 4'b1101,
                                 4'b1010, 4'b0101, 4'b1110, 4'b0111};

    function automatic logic [3:0] seq(input int k);
        return seq_tbl[k % 16];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] d, input logic c,
                       input logic l, input logic e, input logic w, input logic [7:0] ec);
        vec_t t;
        t.v = v; t.d = d; t.c = c;
        t.e_locked = l; t.e_err = e; t.e_wrap = w; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    // One sample per call; inputs return idle right after the capturing edge.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        cfsr_in  = d;
        clr      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].c);
            chk($sformatf("%s[%0d].locked", tag, i), 32'(locked), 32'(vecs[i].e_locked));
            chk($sformatf("%s[%0d].err", tag, i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("%s[%0d].wrap", tag, i), 32'(wrap), 32'(vecs[i].e_wrap));
            chk($sformatf("%s[%0d].err_cnt", tag, i), 32'(err_cnt), 32'(vecs[i].e_cnt));
        end
        vecs.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int rs_idx [8] = '{0, 1, 2, 7, 8, 9, 10, 11};

        rst      = 1'b1;
        in_valid = 1'b0;
        cfsr_in  = 4'd0;
        clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.locked", 32'(locked), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.wrap", 32'(wrap), 32'd0);
        chk("reset.err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean stream: lock after the 5th sample, wrap on every 1111 once locked.
        for (k = 0; k <= 36; k++)
            add(1'b1, seq(k), 1'b0, k >= 4, 1'b0, (k >= 16) && (k % 16 == 0), 8'd0);
        // One corrupted 0010 -> 0011.
        add(1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        for (k = 38; k <= 47; k++)
            add(1'b1, seq(k), 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        // Idle gaps of 1..3 cycles with garbage on cfsr_in.
        for (k = 48; k <= 65; k++) begin
            add(1'b1, seq(k), 1'b0, 1'b1, 1'b0, k % 16 == 0, 8'd1);
            for (int g = 0; g < (k % 3) + 1; g++)
                add(1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        end
        // Two consecutive corruptions drop lock; 5 good samples relock.
        add(1'b1, seq(66) ^ 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
        add(1'b1, seq(67) ^ 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        for (k = 68; k <= 72; k++)
            add(1'b1, seq(k), 1'b0, k == 72, 1'b0, 1'b0, 8'd3);
        run_table("main");

        // Error pulse in flight, then asynchronous reset between edges.
        step(1'b1, seq(73) ^ 4'h8, 1'b0);
        chk("pre_rst.err", 32'(err), 32'd1);
        chk("pre_rst.err_cnt", 32'(err_cnt), 32'd4);
        chk("pre_rst.locked", 32'(locked), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.locked", 32'(locked), 32'd0);
        chk("async_rst.err", 32'(err), 32'd0);
        chk("async_rst.wrap", 32'(wrap), 32'd0);
        chk("async_rst.err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reacquire with a mismatch in ACQUIRE that must restart the match count.
        foreach (rs_idx[i])
            add(1'b1, seq(rs_idx[i]), 1'b0, i == 7, 1'b0, 1'b0, 8'd0);
        // clr alone leaves lock untouched.
        add(1'b1, seq(12), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        run_table("relock");

        // Saturation: alternate bad/good so lock is kept.
        k = 13;
        for (int i = 0; i < 255; i++) begin
            step(1'b1, seq(k) ^ 4'h8, 1'b0);
            k++;
            chk($sformatf("sat[%0d].err", i), 32'(err), 32'd1);
            step(1'b1, seq(k), 1'b0);
            k++;
            chk($sformatf("sat[%0d].locked", i), 32'(locked), 32'd1);
        end
        chk("sat.err_cnt_255", 32'(err_cnt), 32'd255);
        step(1'b1, seq(k) ^ 4'h8, 1'b0);
        k++;
        chk("sat_hold.err", 32'(err), 32'd1);
        chk("sat_hold.err_cnt", 32'(err_cnt), 32'd255);
        step(1'b1, seq(k), 1'b0);
        k++;
        step(1'b1, seq(k) ^ 4'h8, 1'b1);
        k++;
        chk("clr_err.err", 32'(err), 32'd1);
        chk("clr_err.err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_err.locked", 32'(locked), 32'd1);
        step(1'b1, seq(k), 1'b0);
        chk("after_clr.err", 32'(err), 32'd0);
        chk("after_clr.err_cnt", 32'(err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
